// File: rtl/lock_pkg.sv
// Shared types and key-code constants for the keypad lock controller.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by the OPEN, LOCKOUT and entry-timeout phases.
// load_val is the phase length minus one; expire pulses in the phase's last cycle.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic         running;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= load_val;
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

  assign expire = running && (cnt == '0);

endmodule

// File: rtl/entry_sequencer.sv
// Keypad-lock entry controller: assembles digits, runs the compare handshake, sequences open/lockout.
// Optional build macro ENTRY_TIMEOUT_EN adds an inactivity timeout while in ENTRY.
module entry_sequencer
  import lock_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int MAX_WRONG   = 3,
  parameter int OPEN_CYC    = 50_000_000,
  parameter int LOCKOUT_CYC = 500_000_000,
  parameter int TIMEOUT_CYC = 250_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic                cmp_ack,
  input  logic                cmp_match,
  output logic                cmp_req,
  output logic [4*DIGITS-1:0] entry_code,
  output logic [2:0]          digit_cnt,
  output logic                open,
  output logic                lock,
  output logic                lockout,
  output logic [3:0]          wrong_cnt,
  output state_t              state_dbg
);

  localparam int MAX_OL  = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int MAX_DUR = (MAX_OL > TIMEOUT_CYC) ? MAX_OL : TIMEOUT_CYC;
  localparam int TW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  state_t                state, state_n;
  logic [4*DIGITS-1:0]   code_n;
  logic [2:0]            cnt_n;
  logic [3:0]            wrong_n;
  logic                  t_load, t_expire;
  logic [TW-1:0]         t_val;
  logic                  is_digit;

  assign is_digit = key_valid && (key_code <= 4'd9);

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .expire   (t_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      entry_code <= '0;
      digit_cnt  <= '0;
      wrong_cnt  <= '0;
    end else begin
      state      <= state_n;
      entry_code <= code_n;
      digit_cnt  <= cnt_n;
      wrong_cnt  <= wrong_n;
    end
  end

  // Compare handshake: cmp_req is high for every cycle spent in CHECK; a single-cycle
  // cmp_ack (any cycle while cmp_req=1) carries cmp_match and ends the compare.
  always_comb begin
    state_n = state;
    code_n  = entry_code;
    cnt_n   = digit_cnt;
    wrong_n = wrong_cnt;
    t_load  = 1'b0;
    t_val   = '0;
    case (state)
      ST_IDLE: begin
        if (is_digit) begin
          code_n  = {entry_code[4*DIGITS-5:0], key_code};
          cnt_n   = 3'd1;
          state_n = ST_ENTRY;
`ifdef ENTRY_TIMEOUT_EN
          t_load  = 1'b1;
          t_val   = TW'(TIMEOUT_CYC - 1);
`endif
        end
      end
      ST_ENTRY: begin
`ifdef ENTRY_TIMEOUT_EN
        if (t_expire) begin
          code_n  = '0;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else
`endif
        if (key_valid) begin
`ifdef ENTRY_TIMEOUT_EN
          t_load = 1'b1;
          t_val  = TW'(TIMEOUT_CYC - 1);
`endif
          if (is_digit) begin
            if (digit_cnt < 3'(DIGITS)) begin
              code_n = {entry_code[4*DIGITS-5:0], key_code};
              cnt_n  = digit_cnt + 3'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            code_n  = '0;
            cnt_n   = '0;
            state_n = ST_IDLE;
          end else if (key_code == KEY_ENTER) begin
            if (digit_cnt == 3'(DIGITS)) begin
              state_n = ST_CHECK;
            end else begin
              code_n  = '0;
              cnt_n   = '0;
              state_n = ST_IDLE;
            end
          end
        end
      end
      ST_CHECK: begin
        if (cmp_ack) begin
          if (cmp_match) begin
            wrong_n = '0;
            state_n = ST_OPEN;
            t_load  = 1'b1;
            t_val   = TW'(OPEN_CYC - 1);
          end else begin
            wrong_n = (wrong_cnt == 4'(MAX_WRONG)) ? wrong_cnt : wrong_cnt + 4'd1;
            code_n  = '0;
            cnt_n   = '0;
            if (wrong_n == 4'(MAX_WRONG)) begin
              state_n = ST_LOCKOUT;
              t_load  = 1'b1;
              t_val   = TW'(LOCKOUT_CYC - 1);
            end else begin
              state_n = ST_IDLE;
            end
          end
        end
      end
      ST_OPEN: begin
        if (t_expire) state_n = ST_IDLE;
        else if (key_valid && key_code == KEY_ENTER) state_n = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (t_expire) begin
          wrong_n = '0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    cmp_req   = (state == ST_CHECK);
    open      = (state == ST_OPEN);
    lock      = (state != ST_OPEN);
    lockout   = (state == ST_LOCKOUT);
    state_dbg = state;
  end

endmodule

// File: tb/tb_entry_sequencer.sv
// Directed bench for entry_sequencer with short phase durations.
module tb_entry_sequencer;
  import lock_pkg::*;

  localparam int OPEN_CYC    = 8;
  localparam int LOCKOUT_CYC = 12;
  localparam int TIMEOUT_CYC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        cmp_ack = 1'b0;
  logic        cmp_match = 1'b0;
  logic        cmp_req;
  logic [15:0] entry_code;
  logic [2:0]  digit_cnt;
  logic        open;
  logic        lock;
  logic        lockout;
  logic [3:0]  wrong_cnt;
  state_t      state_dbg;

  int tests = 0;
  int fails = 0;

  entry_sequencer #(
    .DIGITS(4), .MAX_WRONG(3), .OPEN_CYC(OPEN_CYC),
    .LOCKOUT_CYC(LOCKOUT_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .cmp_ack(cmp_ack), .cmp_match(cmp_match), .cmp_req(cmp_req),
    .entry_code(entry_code), .digit_cnt(digit_cnt), .open(open), .lock(lock),
    .lockout(lockout), .wrong_cnt(wrong_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // All tasks start and end on a falling edge; outputs are sampled there.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic ack_pulse(input logic m);
    cmp_ack   = 1'b1;
    cmp_match = m;
    @(negedge clk);
    cmp_ack   = 1'b0;
    cmp_match = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_code"}, 32'(entry_code), 32'h0);
    chk({tag, "_cnt"}, 32'(digit_cnt), 32'd0);
    chk({tag, "_req"}, 32'(cmp_req), 32'd0);
    chk({tag, "_open"}, 32'(open), 32'd0);
    chk({tag, "_lock"}, 32'(lock), 32'd1);
    chk({tag, "_lockout"}, 32'(lockout), 32'd0);
    chk({tag, "_wrong"}, 32'(wrong_cnt), 32'd0);
    chk({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    int n;
    @(negedge clk);
    idle(2);
    chk_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full entry, matching ack three cycles into the compare.
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("t1_code", 32'(entry_code), 32'h1234);
    chk("t1_cnt", 32'(digit_cnt), 32'd4);
    press(KEY_ENTER);
    chk("t1_req_rise", 32'(cmp_req), 32'd1);
    idle(2);
    chk("t1_req_held", 32'(cmp_req), 32'd1);
    chk("t1_code_held", 32'(entry_code), 32'h1234);
    ack_pulse(1'b1);
    chk("t1_req_fall", 32'(cmp_req), 32'd0);
    chk("t1_lock", 32'(lock), 32'd0);
    chk("t1_wrong", 32'(wrong_cnt), 32'd0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!open) break;
      n++;
      @(negedge clk);
    end
    chk("t1_open_len", 32'(n), 32'(OPEN_CYC));
    chk("t1_after_open", 32'(state_dbg), 32'(ST_IDLE));

    // Partial entry with CLEAR, then short ENTER.
    press(4'd5);
    chk("t2_code_5", 32'(entry_code), 32'h2345);
    press(4'd6);
    chk("t2_cnt_2", 32'(digit_cnt), 32'd2);
    press(KEY_CLEAR);
    chk("t2_clear_code", 32'(entry_code), 32'h0);
    chk("t2_clear_state", 32'(state_dbg), 32'(ST_IDLE));
    press(4'd7);
    chk("t2_code_7", 32'(entry_code), 32'h0007);
    press(KEY_ENTER);
    chk("t2_short_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("t2_short_req", 32'(cmp_req), 32'd0);
    chk("t2_short_code", 32'(entry_code), 32'h0);
    chk("t2_short_wrong", 32'(wrong_cnt), 32'd0);

    // Three mismatches lead to lockout; keys during lockout are ignored.
    for (int r = 1; r <= 3; r++) begin
      press(4'd9); press(4'd8); press(4'd7); press(4'd6);
      press(KEY_ENTER);
      chk("t3_req", 32'(cmp_req), 32'd1);
      ack_pulse(1'b0);
      chk("t3_wrong", 32'(wrong_cnt), 32'(r));
      chk("t3_code_clr", 32'(entry_code), 32'h0);
      chk("t3_state", 32'(state_dbg), (r == 3) ? 32'(ST_LOCKOUT) : 32'(ST_IDLE));
    end
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!lockout) break;
      n++;
      key_valid = 1'b1;
      key_code  = 4'($urandom_range(0, 9));
      @(negedge clk);
    end
    key_valid = 1'b0;
    chk("t3_lockout_len", 32'(n), 32'(LOCKOUT_CYC));
    chk("t3_post_wrong", 32'(wrong_cnt), 32'd0);
    chk("t3_post_code", 32'(entry_code), 32'h0);
    chk("t3_post_cnt", 32'(digit_cnt), 32'd0);
    chk("t3_post_state", 32'(state_dbg), 32'(ST_IDLE));

    // Stray ack outside CHECK, then one mismatch; CLEAR keeps wrong_cnt.
    ack_pulse(1'b1);
    chk("t4_stray_ack", 32'(state_dbg), 32'(ST_IDLE));
    press(4'd2); press(4'd2); press(4'd2); press(4'd2); press(KEY_ENTER);
    ack_pulse(1'b0);
    chk("t4_wrong1", 32'(wrong_cnt), 32'd1);
    press(4'd3); press(KEY_CLEAR);
    chk("t4_clear_wrong", 32'(wrong_cnt), 32'd1);

    // Extra digits dropped; keys during compare ignored.
    for (int d = 1; d <= 6; d++) press(4'(d));
    chk("t4_drop_code", 32'(entry_code), 32'h1234);
    chk("t4_drop_cnt", 32'(digit_cnt), 32'd4);
    press(KEY_ENTER);
    press(4'd7); press(KEY_CLEAR);
    chk("t4_check_code", 32'(entry_code), 32'h1234);
    chk("t4_check_cnt", 32'(digit_cnt), 32'd4);
    chk("t4_check_req", 32'(cmp_req), 32'd1);

    // Reset mid-compare, then a late ack.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_values("t5_rst");
    ack_pulse(1'b1);
    chk("t5_late_open", 32'(open), 32'd0);
    chk("t5_late_state", 32'(state_dbg), 32'(ST_IDLE));

    // Inactivity during entry.
    press(4'd9);
    chk("t6_code", 32'(entry_code), 32'h0009);
    idle(TIMEOUT_CYC - 1);
    chk("t6_before_exp", 32'(state_dbg), 32'(ST_ENTRY));
    idle(1);
`ifdef ENTRY_TIMEOUT_EN
    chk("t6_to_code", 32'(entry_code), 32'h0);
    chk("t6_to_cnt", 32'(digit_cnt), 32'd0);
    chk("t6_to_state", 32'(state_dbg), 32'(ST_IDLE));
`else
    chk("t6_hold_code", 32'(entry_code), 32'h0009);
    chk("t6_hold_state", 32'(state_dbg), 32'(ST_ENTRY));
`endif

    // ENTER during OPEN re-locks at once.
    press(KEY_CLEAR);
    press(4'd4); press(4'd3); press(4'd2); press(4'd1); press(KEY_ENTER);
    ack_pulse(1'b1);
    chk("t7_open", 32'(open), 32'd1);
    idle(2);
    press(4'd5);
    chk("t7_digit_ignored", 32'(open), 32'd1);
    press(KEY_ENTER);
    chk("t7_relock_open", 32'(open), 32'd0);
    chk("t7_relock_lock", 32'(lock), 32'd1);
    chk("t7_relock_state", 32'(state_dbg), 32'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
